modn_pwm_gen: RTL

- Downstream consumer of the mod-N counter's count bus.
- Tracks the counter's wrap from N-1 to 0 and checks that the count sequence stays continuous.
- Generates a PWM output whose duty is loaded through a valid/ready handshake and double-buffered so that a new duty only takes effect at a period boundary.
- Also reports wrap pulses, a saturating period count, lock status and a sticky sync-error flag.

---
 rtl/modn_pwm_gen.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/modn_pwm_gen.sv
// modn_pwm_gen
// Follows the count bus of a mod-N counter in the same clock domain. It
// detects the N-1 -> 0 wrap, checks that the count sequence is continuous,
// and drives a PWM output whose duty is double-buffered so that a new duty
// only takes effect at a period boundary.
//
// Ports:
//   clk        rising-edge system clock
//   rst        asynchronous reset, active-low
//   en         block enable; low forces IDLE on the next edge
//   count      count value from the mod-N counter (0..N-1)
//   duty_in    requested duty in counts per period (values above N clamp to N)
//   duty_valid duty_in is offered (held by the source until accepted)
//   duty_ready shadow register is free
//   pwm        PWM output, one cycle behind count
//   wrap       one-cycle pulse after each detected wrap in SYNC or RUN
//   cycles     completed periods while locked, saturating
//   locked     high while in RUN
//   sync_err   sticky count-discontinuity flag
//   clr_err    clears sync_err (a new error in the same cycle wins)
module modn_pwm_gen #(
  parameter int N      = 16,
  parameter int WIDTH  = $clog2(N),
  parameter int DUTY_W = $clog2(N + 1),
  parameter int CYC_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [WIDTH-1:0]  count,
  input  logic [DUTY_W-1:0] duty_in,
  input  logic              duty_valid,
  output logic              duty_ready,
  output logic              pwm,
  output logic              wrap,
  output logic [CYC_W-1:0]  cycles,
  output logic              locked,
  output logic              sync_err,
  input  logic              clr_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0]  CNT_LAST = WIDTH'(N - 1);
  localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(N);
  localparam logic [CYC_W-1:0]  CYC_MAX  = '1;

  // Requested duty values above N mean "always on"; clamp them to N.
  function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] d);
    return (d > DUTY_MAX) ? DUTY_MAX : d;
  endfunction

  // Period counter holds at its maximum instead of rolling over.
  function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] c);
    return (c == CYC_MAX) ? c : c + CYC_W'(1);
  endfunction

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   prev_cnt;
  logic [WIDTH-1:0]   cnt_succ;
  logic [DUTY_W-1:0]  duty_act;
  logic [DUTY_W-1:0]  shadow;
  logic [DUTY_W-1:0]  duty_next;
  logic               pending;
  logic               w_hit;
  logic               c_ok;
  logic               err_evt;
  logic               accept;
  logic               copy;

  // Expected successor of the previous sample, modulo N.
  assign cnt_succ   = (prev_cnt == CNT_LAST) ? '0 : prev_cnt + WIDTH'(1);
  assign w_hit      = (prev_cnt == CNT_LAST) && (count == '0);
  assign c_ok       = (count == cnt_succ);
  assign err_evt    = (state == RUN) && !c_ok;

  // Handshake: a transfer is only possible while the shadow is empty, so an
  // accept coincident with a wrap never collides with the shadow copy.
  assign duty_ready = !pending;
  assign accept     = duty_valid && !pending;
  assign copy       = pending && ((state == IDLE) || w_hit);

  // On a wrap edge with a pending duty, the new duty already governs the
  // first PWM sample of the new period.
  assign duty_next  = (w_hit && pending) ? shadow : duty_act;

  assign locked     = (state == RUN);

  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = SYNC;
        SYNC:    if (w_hit) state_nxt = RUN;
        RUN:     if (!c_ok) state_nxt = SYNC;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Stage boundary: state, sampled count and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      prev_cnt <= '0;
      pwm      <= 1'b0;
      wrap     <= 1'b0;
      cycles   <= '0;
      sync_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      prev_cnt <= count;
      pwm      <= (state_nxt == RUN) && (DUTY_W'(count) < duty_next);
      wrap     <= w_hit && (state != IDLE);
      if (!en || (state == IDLE)) begin
        cycles <= '0;
      end else if ((state == RUN) && w_hit) begin
        cycles <= sat_inc(cycles);
      end
      if (err_evt) begin
        sync_err <= 1'b1;
      end else if (clr_err) begin
        sync_err <= 1'b0;
      end
    end
  end

  // Stage boundary: duty double buffer (shadow -> active).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow   <= '0;
      duty_act <= '0;
      pending  <= 1'b0;
    end else if (accept) begin
      shadow   <= clamp_duty(duty_in);
      pending  <= 1'b1;
    end else if (copy) begin
      duty_act <= shadow;
      pending  <= 1'b0;
    end
  end

endmodule
